mem_bank_arb: RTL and testbench

//  Dual-port access arbiter for the 4K RAM built from four 1K single-port banks.

---
 rtl/mem_bank_pkg.sv | 27 ++
 rtl/bank_sel_dec.sv | 18 +
 rtl/mem_bank_arb.sv | 113 +++++++++++
 tb/tb_mem_bank_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_pkg
//  Description : Shared widths and types for the banked-RAM access arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bank_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 12;
    localparam int DEF_NB   = 4;
    localparam int DEF_CNTW = 16;
    localparam int BSW      = $clog2(DEF_NB);
    localparam int BAW      = DEF_AW - BSW;

    typedef struct packed {
        logic           vld;
        logic [BSW-1:0] bank;
    } rd_tag_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage
`default_nettype wire

// File: rtl/bank_sel_dec.sv
`default_nettype none
// ============================================================================
//  Module      : bank_sel_dec
//  Description : Enabled binary-to-one-hot bank select decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_sel_dec #(
    parameter int NB = 4
) (
    input  logic                  en,
    input  logic [$clog2(NB)-1:0] bank,
    output logic [NB-1:0]         sel
);

    assign sel = en ? ({{(NB-1){1'b0}}, 1'b1} << bank) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_arb
//  Description : Two-port arbiter over four single-port RAM banks with
//                per-bank round-robin, registered read return, conflict count.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_arb
    import mem_bank_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int NB   = DEF_NB,
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DW-1:0]     a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DW-1:0]     b_rdata,
    output logic [NB-1:0]     bank_cs,
    output logic [NB-1:0]     bank_we,
    output logic [NB*BAW-1:0] bank_addr,
    output logic [NB*DW-1:0]  bank_wdata,
    input  logic [NB*DW-1:0]  bank_rdata,
    output logic [CNTW-1:0]   conflict_cnt
);

    logic [NB-1:0]   r_prio;
    rd_tag_t         r_a_tag;
    rd_tag_t         r_b_tag;
    logic [DW-1:0]   r_a_rdata;
    logic [DW-1:0]   r_b_rdata;
    logic [CNTW-1:0] r_cnt;

    logic [BSW-1:0]  w_a_bank;
    logic [BSW-1:0]  w_b_bank;
    logic            w_conflict;
    port_e           w_winner;
    logic [NB-1:0]   w_a_sel;
    logic [NB-1:0]   w_b_sel;
    logic [DW-1:0]   w_a_ret;
    logic [DW-1:0]   w_b_ret;

    assign w_a_bank   = a_addr[AW-1:BAW];
    assign w_b_bank   = b_addr[AW-1:BAW];
    assign w_conflict = rst_n & a_req & b_req & (w_a_bank == w_b_bank);
    assign w_winner   = r_prio[w_a_bank] ? PORT_B : PORT_A;

    // Grants are suppressed while reset is asserted so no bank is touched.
    assign a_gnt = rst_n & a_req & (~w_conflict | (w_winner == PORT_A));
    assign b_gnt = rst_n & b_req & (~w_conflict | (w_winner == PORT_B));

    bank_sel_dec #(.NB(NB)) u_dec_a (.en(a_gnt), .bank(w_a_bank), .sel(w_a_sel));
    bank_sel_dec #(.NB(NB)) u_dec_b (.en(b_gnt), .bank(w_b_bank), .sel(w_b_sel));

    for (genvar i = 0; i < NB; i++) begin : g_bank
        assign bank_cs[i] = w_a_sel[i] | w_b_sel[i];
        assign bank_we[i] = (w_a_sel[i] & a_we) | (w_b_sel[i] & b_we);
        assign bank_addr[i*BAW +: BAW] = w_a_sel[i] ? a_addr[BAW-1:0] :
                                         w_b_sel[i] ? b_addr[BAW-1:0] : '0;
        assign bank_wdata[i*DW +: DW]  = w_a_sel[i] ? a_wdata :
                                         w_b_sel[i] ? b_wdata : '0;
    end

    assign w_a_ret = bank_rdata[r_a_tag.bank*DW +: DW];
    assign w_b_ret = bank_rdata[r_b_tag.bank*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio    <= '0;
            r_a_tag   <= '0;
            r_b_tag   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_cnt     <= '0;
        end else begin
            // The loser of a conflict is favoured next time in that bank.
            if (w_conflict) begin
                r_prio[w_a_bank] <= (w_winner == PORT_A);
                if (r_cnt != '1)
                    r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
            r_a_tag.vld  <= a_gnt & ~a_we;
            r_a_tag.bank <= w_a_bank;
            r_b_tag.vld  <= b_gnt & ~b_we;
            r_b_tag.bank <= w_b_bank;
            if (r_a_tag.vld)
                r_a_rdata <= w_a_ret;
            if (r_b_tag.vld)
                r_b_rdata <= w_b_ret;
        end
    end

    assign a_rvalid     = r_a_tag.vld;
    assign b_rvalid     = r_b_tag.vld;
    assign a_rdata      = r_a_tag.vld ? w_a_ret : r_a_rdata;
    assign b_rdata      = r_b_tag.vld ? w_b_ret : r_b_rdata;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bank_arb
//  Description : Self-checking bench for mem_bank_arb against a 4K-word model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_arb;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0]  a_rdata, b_rdata;
    logic [3:0]  bank_cs, bank_we;
    logic [39:0] bank_addr;
    logic [31:0] bank_wdata;
    logic [31:0] bank_rdata = '0;
    logic [15:0] conflict_cnt;

    logic        u4_a_gnt, u4_a_rvalid, u4_b_gnt, u4_b_rvalid;
    logic [7:0]  u4_a_rdata, u4_b_rdata;
    logic [3:0]  u4_bank_cs, u4_bank_we;
    logic [39:0] u4_bank_addr;
    logic [31:0] u4_bank_wdata;
    logic [3:0]  u4_conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mem_bank_arb u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .bank_cs(bank_cs), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter instance shares the stimulus to exercise saturation.
    mem_bank_arb #(.CNTW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(u4_a_gnt), .a_rvalid(u4_a_rvalid), .a_rdata(u4_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(u4_b_gnt), .b_rvalid(u4_b_rvalid), .b_rdata(u4_b_rdata),
        .bank_cs(u4_bank_cs), .bank_we(u4_bank_we), .bank_addr(u4_bank_addr),
        .bank_wdata(u4_bank_wdata), .bank_rdata(bank_rdata),
        .conflict_cnt(u4_conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Four 1K single-port banks with one-cycle read latency.
    logic [7:0] ram [4][1024] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bank_cs[i]) begin
                if (bank_we[i])
                    ram[i][bank_addr[i*10 +: 10]] <= bank_wdata[i*8 +: 8];
                else
                    bank_rdata[i*8 +: 8] <= ram[i][bank_addr[i*10 +: 10]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flat 4K memory, per-bank "B is owed a win" flags.
    logic [7:0] m_mem [4096] = '{default: '0};
    logic [3:0] m_favour_b;
    logic       m_pa_v, m_pb_v;
    logic [7:0] m_pa_d, m_pb_d, m_ha, m_hb;
    int         m_cnt, m_cnt4;

    task automatic model_step();
        int         ab, bb;
        logic       clash, ea, eb;
        logic [3:0] e_cs, e_we;
        logic [39:0] e_addr;
        logic [31:0] e_wd;
        if (!rst_n) begin
            chk("rst_gnt",    {a_gnt, b_gnt}, 0);
            chk("rst_cs",     bank_cs, 0);
            chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
            chk("rst_rdata",  {a_rdata, b_rdata}, 0);
            chk("rst_cnt",    conflict_cnt, 0);
            chk("rst_cnt4",   u4_conflict_cnt, 0);
            m_favour_b = '0;
            m_pa_v = 1'b0; m_pb_v = 1'b0;
            m_pa_d = '0;   m_pb_d = '0;
            m_ha = '0;     m_hb = '0;
            m_cnt = 0;     m_cnt4 = 0;
            return;
        end
        ab    = int'(a_addr) / 1024;
        bb    = int'(b_addr) / 1024;
        clash = a_req && b_req && (ab == bb);
        ea    = a_req && !(clash && m_favour_b[ab]);
        eb    = b_req && !(clash && !m_favour_b[bb]);
        e_cs = '0; e_we = '0; e_addr = '0; e_wd = '0;
        if (ea) begin
            e_cs[ab] = 1'b1; e_we[ab] = a_we;
            e_addr[ab*10 +: 10] = a_addr[9:0]; e_wd[ab*8 +: 8] = a_wdata;
        end
        if (eb) begin
            e_cs[bb] = 1'b1; e_we[bb] = b_we;
            e_addr[bb*10 +: 10] = b_addr[9:0]; e_wd[bb*8 +: 8] = b_wdata;
        end
        chk("m_gnt",    {a_gnt, b_gnt}, {ea, eb});
        chk("m_cs",     bank_cs, e_cs);
        chk("m_we",     bank_we, e_we);
        chk("m_addr",   bank_addr, e_addr);
        chk("m_wdata",  bank_wdata, e_wd);
        chk("m_rvalid", {a_rvalid, b_rvalid}, {m_pa_v, m_pb_v});
        chk("m_a_rdata", a_rdata, m_pa_v ? m_pa_d : m_ha);
        chk("m_b_rdata", b_rdata, m_pb_v ? m_pb_d : m_hb);
        chk("m_cnt",    conflict_cnt, m_cnt);
        chk("m_cnt4",   u4_conflict_cnt, m_cnt4);
        if (m_pa_v) m_ha = m_pa_d;
        if (m_pb_v) m_hb = m_pb_d;
        m_pa_v = ea && !a_we; m_pa_d = m_mem[a_addr];
        m_pb_v = eb && !b_we; m_pb_d = m_mem[b_addr];
        if (ea && a_we) m_mem[a_addr] = a_wdata;
        if (eb && b_we) m_mem[b_addr] = b_wdata;
        if (clash) begin
            m_favour_b[ab] = ea;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(output logic req, output logic we,
                           output logic [11:0] addr, output logic [7:0] wd);
        req  = ($urandom_range(0, 3) != 0);
        we   = $urandom_range(0, 1) == 1;
        addr = 12'(($urandom_range(0, 3) << 10) | $urandom_range(0, 15));
        wd   = 8'($urandom);
    endtask

    logic ga, gb;

    initial begin
        rst_n = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_cnt", conflict_cnt, 0);
        chk("init_rvalid", {a_rvalid, b_rvalid}, 0);

        // Different banks: both served together.
        step();
        a_req = 1; a_we = 0; a_addr = 12'h005;
        b_req = 1; b_we = 1; b_addr = 12'h805; b_wdata = 8'h3C;
        @(negedge clk);
        chk("nc_gnt", {a_gnt, b_gnt}, 2'b11);
        chk("nc_cs", bank_cs, 4'b0101);
        chk("nc_we", bank_we, 4'b0100);
        chk("nc_addr2", bank_addr[20 +: 10], 10'h005);
        step();
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("nc_rvalid", {a_rvalid, b_rvalid}, 2'b10);

        // Same bank held four cycles: alternating winners.
        step();
        a_req = 1; a_we = 0; a_addr = 12'h400;
        b_req = 1; b_we = 0; b_addr = 12'h7FF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", {a_gnt, b_gnt}, (i % 2 == 1) ? 2'b01 : 2'b10);
            step();
        end
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("rr_cnt", conflict_cnt, 16'd4);

        // Write then read of the same word in bank 0.
        step();
        a_req = 1; a_we = 1; a_addr = 12'h123; a_wdata = 8'hA5;
        b_req = 1; b_we = 0; b_addr = 12'h123;
        @(negedge clk);
        chk("wr_gnt", {a_gnt, b_gnt}, 2'b10);
        step();
        a_req = 0;
        @(negedge clk);
        chk("wr_bgnt", b_gnt, 1'b1);
        step();
        b_req = 0;
        @(negedge clk);
        chk("wr_rvalid", b_rvalid, 1'b1);
        chk("wr_rdata", b_rdata, 8'hA5);

        // Twenty conflict cycles in bank 3.
        step();
        a_req = 1; a_we = 0; a_addr = 12'hC00;
        b_req = 1; b_we = 0; b_addr = 12'hC01;
        repeat (20) step();
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("sat_cnt4", u4_conflict_cnt, 4'd15);
        chk("sat_cnt16", conflict_cnt, 16'd25);

        // Random traffic obeying hold-until-grant, with occasional abandonment.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ga = a_gnt; gb = b_gnt;
            @(posedge clk);
            #1;
            if (!a_req || ga || $urandom_range(0, 15) == 0)
                new_req(a_req, a_we, a_addr, a_wdata);
            if (!b_req || gb || $urandom_range(0, 15) == 0)
                new_req(b_req, b_we, b_addr, b_wdata);
        end

        // Asynchronous reset in the middle of a cycle with traffic active.
        a_req = 1; a_we = 0; a_addr = 12'h001;
        b_req = 1; b_we = 0; b_addr = 12'h401;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("arst_cs", bank_cs, 0);
        chk("arst_cnt", conflict_cnt, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_req = 0; b_req = 0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
